// File: rtl/dpm_pkg.sv
// Shared types and default sizes for the duty/period meter.
// Defining DPM_TIMEOUT_EN enables the saturation-timeout abort in duty_period_meter.
package dpm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } dpm_state_t;

   localparam int DEF_CNT_W       = 16;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser chain for an asynchronous input plus one delay flop for edge detection.
// rise/fall are single-cycle pulses derived from the synchronised level.
module sync_edge_det
   import dpm_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic s_sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s_d_q;
   logic                   s_d_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_d  = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         s_d_q  <= s_d_d;
      end
   end

   assign s_sync = sync_q[SYNC_STAGES-1];
   assign rise   = s_sync & ~s_d_q;
   assign fall   = ~s_sync & s_d_q;

endmodule

// File: rtl/duty_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Optional macro DPM_TIMEOUT_EN: abort with done+timeout when the counter saturates.
module duty_period_meter
   import dpm_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             s_sync;
   logic             rise;
   logic             fall;

   dpm_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             at_max;
`ifdef DPM_TIMEOUT_EN
   logic             timeout_q, timeout_d;
`endif

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .s_sync (s_sync),
      .rise   (rise),
      .fall   (fall)
   );

   always_comb begin
      at_max      = (cnt_q == CNT_MAX);
      // Counter never wraps: a stuck input parks it at all-ones.
      cnt_inc     = at_max ? CNT_MAX : cnt_q + 1'b1;
      state_d     = state_q;
      cnt_d       = cnt_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      done_d      = 1'b0;
`ifdef DPM_TIMEOUT_EN
      timeout_d   = timeout_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ARM;
               cnt_d   = '0;
            end
         end
         ARM: begin
            if (rise) begin
               cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
               state_d = HIGH;
`ifdef DPM_TIMEOUT_EN
            end else if (at_max) begin
               state_d     = IDLE;
               done_d      = 1'b1;
               timeout_d   = 1'b1;
               period_d    = CNT_MAX;
               high_time_d = CNT_MAX;
`endif
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HIGH: begin
            if (fall) begin
               high_time_d = cnt_q;
               cnt_d       = cnt_inc;
               state_d     = LOW;
`ifdef DPM_TIMEOUT_EN
            end else if (at_max) begin
               state_d     = IDLE;
               done_d      = 1'b1;
               timeout_d   = 1'b1;
               period_d    = CNT_MAX;
               high_time_d = CNT_MAX;
`endif
            end else begin
               cnt_d = cnt_inc;
            end
         end
         LOW: begin
            if (rise) begin
               period_d = cnt_q;
               done_d   = 1'b1;
               state_d  = IDLE;
`ifdef DPM_TIMEOUT_EN
               timeout_d = 1'b0;
            end else if (at_max) begin
               // high_time from this run is kept; only the period is unknown.
               state_d   = IDLE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               period_d  = CNT_MAX;
`endif
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef DPM_TIMEOUT_EN
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef DPM_TIMEOUT_EN
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign period    = period_q;
   assign high_time = high_time_q;
`ifdef DPM_TIMEOUT_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_duty_period_meter.sv
// Directed + randomized bench for duty_period_meter against an edge-list reference model.
// A second 4-bit instance exercises counter saturation (DPM_TIMEOUT_EN aware).
module tb_duty_period_meter;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        sig_in, start, busy, done, timeout;
   logic [15:0] period, high_time;
   logic        sig4, start4, busy4, done4, timeout4;
   logic [3:0]  period4, high4;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   // sig_in change log (cycle of drive, new level) and done log of the main DUT
   int          e_cyc[$];
   bit          e_lvl[$];
   int          d_cyc[$];
   logic [15:0] d_per[$];
   logic [15:0] d_hi[$];
   logic        d_to[$];

   duty_period_meter #(.CNT_W(16), .SYNC_STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .busy(busy),
      .done(done), .period(period), .high_time(high_time), .timeout(timeout)
   );

   duty_period_meter #(.CNT_W(4), .SYNC_STAGES(S)) u_dut4 (
      .clk(clk), .rst(rst), .sig_in(sig4), .start(start4), .busy(busy4),
      .done(done4), .period(period4), .high_time(high4), .timeout(timeout4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
         d_cyc.push_back(cyc);
         d_per.push_back(period);
         d_hi.push_back(high_time);
         d_to.push_back(timeout);
      end
   endtask

   task automatic set_sig(input bit v);
      if (v != sig_in) begin
         e_cyc.push_back(cyc);
         e_lvl.push_back(v);
      end
      sig_in = v;
   endtask

   // Reference: a sig_in change driven after clock edge c is seen S+1 edges later;
   // the measurement uses the first rise visible once armed, the next fall and the next rise.
   task automatic model(input int s, output bit ok, output int per, output int hi, output int dcyc);
      int r1 = -1, f = -1, r2 = -1;
      foreach (e_cyc[i]) begin
         if (e_cyc[i] < s + 1 - S) continue;
         if (r1 < 0) begin
            if (e_lvl[i]) r1 = e_cyc[i];
         end else if (f < 0) begin
            if (!e_lvl[i]) f = e_cyc[i];
         end else if (r2 < 0) begin
            if (e_lvl[i]) r2 = e_cyc[i];
         end
      end
      ok   = (r2 >= 0);
      per  = r2 - r1;
      hi   = f - r1;
      dcyc = r2 + S + 1;
   endtask

   task automatic check_done(input string tag, input int idx, input int s);
      bit ok;
      int per, hi, dc;
      model(s, ok, per, hi, dc);
      chk({tag, "_model_ok"}, ok, 1'b1);
      if (ok && d_cyc.size() > idx) begin
         chk({tag, "_done_cyc"}, d_cyc[idx], dc);
         chk({tag, "_period"}, d_per[idx], per);
         chk({tag, "_high"}, d_hi[idx], hi);
         chk({tag, "_timeout"}, d_to[idx], 1'b0);
      end
   endtask

   task automatic run_meas(input string tag, input int h, input int l, input int gap,
                           input bit pre_high, input bit poke_busy, input bit b2b);
      int s, s2, k, p, total, ndone;
      bit lvl, b2b_fired;
      e_cyc.delete(); e_lvl.delete();
      d_cyc.delete(); d_per.delete(); d_hi.delete(); d_to.delete();
      set_sig(pre_high);
      repeat (6) tick();
      e_cyc.delete(); e_lvl.delete();
      start = 1'b1;
      s = cyc;
      tick();
      start = 1'b0;
      chk({tag, "_busy_after_start"}, busy, 1'b1);
      b2b_fired = 1'b0;
      s2 = 0;
      total = gap + (b2b ? 6 : 4) * (h + l) + 20;
      for (k = 0; k < total; k++) begin
         p = pre_high ? k : k - gap;
         lvl = (p >= 0) && ((p % (h + l)) < h);
         set_sig(lvl);
         if (poke_busy && k == gap + 3) start = 1'b1;
         ndone = d_cyc.size();
         if (b2b && !b2b_fired && ndone == 1 && d_cyc[0] == cyc) begin
            start = 1'b1;
            s2 = cyc;
            b2b_fired = 1'b1;
            tick();
            start = 1'b0;
            chk({tag, "_b2b_busy"}, busy, 1'b1);
            continue;
         end
         tick();
         start = 1'b0;
      end
      chk({tag, "_ndone"}, d_cyc.size(), b2b ? 2 : 1);
      check_done(tag, 0, s);
      if (b2b) check_done({tag, "_2nd"}, 1, s2);
      chk({tag, "_busy_end"}, busy, 1'b0);
   endtask

   initial begin
      int gap, s4, seen;
      bit pre;
      rst = 1'b1; sig_in = 1'b0; start = 1'b0; sig4 = 1'b0; start4 = 1'b0;
      // Reset with toggling input
      for (int i = 0; i < 3; i++) begin
         sig_in = ~sig_in;
         tick();
         chk("rst_busy", busy, 1'b0);
         chk("rst_done", done, 1'b0);
         chk("rst_timeout", timeout, 1'b0);
         chk("rst_period", period, 16'd0);
         chk("rst_high", high_time, 16'd0);
      end
      rst = 1'b0;
      tick();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_period", period, 16'd0);

      run_meas("basic", 2, 3, 4, 1'b0, 1'b0, 1'b0);
      chk("basic_p5", period, 16'd5);
      chk("basic_h2", high_time, 16'd2);
      run_meas("prehigh", 3, 4, 0, 1'b1, 1'b0, 1'b0);
      chk("prehigh_p7", period, 16'd7);
      chk("prehigh_h3", high_time, 16'd3);
      run_meas("busyign", 4, 4, 5, 1'b0, 1'b1, 1'b0);
      chk("busyign_p8", period, 16'd8);
      run_meas("b2b", 3, 5, 4, 1'b0, 1'b0, 1'b1);

      for (int n = 0; n < 8; n++) begin
         pre = $urandom_range(0, 1);
         gap = $urandom_range(1, 6);
         run_meas($sformatf("rand%0d", n), $urandom_range(1, 7), $urandom_range(1, 7),
                  gap, pre, 1'b0, 1'b0);
      end

      // Reset while in LOW: pattern 3 high / 6 low, reset well inside the low phase
      d_cyc.delete();
      set_sig(1'b0);
      repeat (6) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         set_sig((k >= 4) && (((k - 4) % 9) < 3));
         if (k == 4 + 3 + 4) rst = 1'b1;
         if (k == 4 + 3 + 6) rst = 1'b0;
         tick();
         if (k == 4 + 3 + 5) begin
            chk("midrst_busy", busy, 1'b0);
            chk("midrst_period", period, 16'd0);
            chk("midrst_high", high_time, 16'd0);
            chk("midrst_timeout", timeout, 1'b0);
         end
      end
      chk("midrst_ndone", d_cyc.size(), 0);
      chk("midrst_busy_end", busy, 1'b0);

      // Saturation on the 4-bit instance, sig4 held low
      start4 = 1'b1;
      s4 = cyc;
      tick();
      start4 = 1'b0;
      chk("to_busy_start", busy4, 1'b1);
      seen = -1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (done4 === 1'b1 && seen < 0) begin
            seen = cyc;
`ifdef DPM_TIMEOUT_EN
            chk("to_timeout", timeout4, 1'b1);
            chk("to_period", period4, 4'hF);
            chk("to_high", high4, 4'hF);
`endif
         end
      end
`ifdef DPM_TIMEOUT_EN
      chk("to_done_cyc", seen, s4 + 17);
      chk("to_busy_end", busy4, 1'b0);
`else
      chk("to_no_done", seen, -1);
      chk("to_busy_held", busy4, 1'b1);
      chk("to_timeout_zero", timeout4, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/duty_period_meter.md
# duty_period_meter

Measures the period and high time of a slow, asynchronous square wave, such as the output of an odd or even clock divider, in cycles of the fast system clock. It sits directly downstream of the clock dividers and serves as the on-chip checker for divider ratio and duty cycle. Each measurement is armed by a start pulse. Results are reported with a one-cycle done strobe and held until the next measurement completes.

## Interface
- CNT_W, 16: width of the cycle counter and of both result outputs.
- SYNC_STAGES, 2: number of synchroniser flops on sig_in (minimum 2).

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous signal under measurement.
- start  in  1  one-cycle request to begin a measurement; honoured only in IDLE.
- busy  out  1  high while a measurement is in progress (any state except IDLE).
- done  out  1  one-cycle strobe; period, high_time and timeout are valid on this cycle.
- period  out  CNT_W  clk cycles between two consecutive rising edges.
- high_time  out  CNT_W  clk cycles from a rising edge to the following falling edge.
- timeout  out  1  last measurement aborted on counter saturation; valid with done, held until the next done.

## Operation
- sig_in passes through SYNC_STAGES flops (reset 0) to give s_sync, then one more flop to give s_d.
- rise = s_sync & ~s_d; fall = ~s_sync & s_d.
- s_d tracks continuously, including in IDLE. A level that is already high at start is therefore never a rise.
- FSM states are IDLE, ARM, HIGH and LOW.
- IDLE: on start go to ARM and clear cnt to 0.
- ARM: on rise set cnt to 1 and go to HIGH. Otherwise increment cnt.
- HIGH: increment cnt every cycle. On fall, latch high_time with the current cnt and go to LOW.
- LOW: increment cnt every cycle. On rise, latch period with the current cnt, pulse done, clear timeout and go to IDLE.
- A rise seen in HIGH, or a fall seen in LOW, is impossible after synchronisation and needs no handling.
- start is ignored while busy. start on the done cycle is accepted, because the state is already IDLE.
- Arithmetic is unsigned CNT_W bits. Minimum results are high_time = 1 and period = 2.
- period and high_time update only on a successful or timed-out completion. Otherwise they hold.

## Timing
- Reset values: busy, done and timeout are 0; period and high_time are 0; state is IDLE; cnt and the sync/edge flops are 0.
- Reset mid-measurement aborts to IDLE with no done, and outputs return to their reset values.
- Latency from a sig_in edge to the rise/fall cycle is SYNC_STAGES+1 clk cycles. Results are unaffected because both edges share this latency.
- busy rises the cycle after start is sampled.
- done, the result update and busy falling all occur in the cycle after the terminating rise.
- Example: rise at cycle 0, fall at cycle 2, rise at cycle 5 gives high_time = 2 and period = 5, with done asserted at cycle 6.

## Configuration
- Macro DPM_TIMEOUT_EN.
- Defined: if cnt equals all-ones in ARM, HIGH or LOW without the awaited edge, the block does the following on the next cycle:
  - goes to IDLE;
  - pulses done;
  - sets timeout to 1;
  - sets period to all-ones;
  - sets high_time to all-ones if the abort happened in ARM or HIGH; otherwise keeps the high_time latched this run.
- Not defined: cnt saturates at all-ones and the FSM waits indefinitely. The timeout output is tied to 0. Only rst or a completed measurement leaves the state.

## Structure
- Package dpm_pkg holds the FSM state typedef (dpm_state_t: IDLE, ARM, HIGH, LOW) and the default CNT_W and SYNC_STAGES localparams.
- Sub-module sync_edge_det contains the synchroniser chain plus the s_d flop, with outputs s_sync, rise and fall.
- The FSM, counter and result registers live in duty_period_meter.

## Test plan
- Reset: assert rst for 3 cycles during sig_in toggling. Expect busy = done = timeout = 0 and period = high_time = 0 throughout and after.
- Basic: start, then drive sig_in synchronously with 2 high and 3 low cycles, repeating. Expect exactly one done, with period = 5 and high_time = 2, and busy low afterwards.
- Pre-high input: sig_in already high when start is sampled, pattern 3 high / 4 low. Expect the first partial high to be ignored, then period = 7 and high_time = 3.
- Busy ignore: second start pulsed while in HIGH, with a 4 high / 4 low pattern. Expect a single done with period = 8, and no new ARM afterwards.
- Back-to-back: start asserted on the done cycle. Expect busy high on the next cycle and a second valid measurement.
- Timeout (DPM_TIMEOUT_EN, CNT_W = 4): sig_in held 0, start at cycle 0. Expect done and timeout at cycle 17, with period = high_time = 4'hF.
- Timeout, macro undefined: same stimulus. Expect no done for 100 cycles and busy held high.
- Reset mid-run: rst asserted while in LOW. Expect no done and all outputs at their reset values.
